// File: rtl/fir_ntap_serial.sv
// Serial N-tap FIR filter: one multiplier and one accumulator walk the taps once per
// accepted sample; the result is held on y behind a valid/ready handshake.
module fir_ntap_serial #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_W-1:0]                           x,
    input  logic                                        coef_we,
    input  logic [$clog2(TAPS)-1:0]                     coef_addr,
    input  logic [COEF_W-1:0]                           coef_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_W+COEF_W+$clog2(TAPS)-1:0]       y
);

    localparam int unsigned AW      = $clog2(TAPS);
    localparam int unsigned ACC_W   = DATA_W + COEF_W + AW;
    localparam int unsigned PROD_W  = DATA_W + COEF_W;
    localparam int unsigned TAPS_M1 = TAPS - 1;
    localparam logic [AW:0]   TAPS_W   = TAPS[AW:0];
    localparam logic [AW-1:0] LAST_IDX = TAPS_M1[AW-1:0];

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [DATA_W-1:0]   r_d [TAPS];
    logic [COEF_W-1:0]   r_h [TAPS];
    logic [AW-1:0]       r_idx;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_y;

    logic                w_idle;
    logic                w_accept;
    logic                w_coef_wr;
    logic                w_last;
    logic [PROD_W-1:0]   w_h_ext;
    logic [PROD_W-1:0]   w_d_ext;
    logic [PROD_W-1:0]   w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    w_sum;

    assign w_idle    = (r_state == StIdle);
    assign w_accept  = in_valid && w_idle;
    // Out-of-range addresses are only possible when TAPS is not a power of two.
    assign w_coef_wr = coef_we && w_idle && ({1'b0, coef_addr} < TAPS_W);
    assign w_last    = (r_idx == LAST_IDX);

    // Both operands sign-extended to the product width so the low bits are exact.
    assign w_h_ext    = {{DATA_W{r_h[r_idx][COEF_W-1]}}, r_h[r_idx]};
    assign w_d_ext    = {{COEF_W{r_d[r_idx][DATA_W-1]}}, r_d[r_idx]};
    assign w_prod     = w_h_ext * w_d_ext;
    assign w_prod_ext = {{AW{w_prod[PROD_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    assign y = r_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = StMac;
                end
            end
            StMac: begin
                if (w_last) begin
                    w_state_next = StOut;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                r_d[i] <= '0;
                r_h[i] <= {{(COEF_W-1){1'b0}}, 1'b1};
            end
            r_idx <= '0;
            r_acc <= '0;
            r_y   <= '0;
        end else begin
            if (w_coef_wr) begin
                r_h[coef_addr] <= coef_data;
            end
            if (w_accept) begin
                r_d[0] <= x;
                for (int unsigned i = 1; i < TAPS; i++) begin
                    r_d[i] <= r_d[i-1];
                end
                r_acc <= '0;
                r_idx <= '0;
            end else if (r_state == StMac) begin
                r_acc <= w_sum;
                r_idx <= r_idx + 1'b1;
                if (w_last) begin
                    r_y <= w_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_ntap_serial.sv
// Self-checking bench for fir_ntap_serial: directed scenarios plus randomized traffic
// compared against a delay-line/coefficient-array reference model.
module tb_fir_ntap_serial;

    localparam int TAPS = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [35:0] y;

    int checks = 0;
    int failures = 0;

    longint h_m [TAPS];
    longint d_m [TAPS];

    fir_ntap_serial dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    function automatic longint model_y();
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += h_m[i] * d_m[i];
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            h_m[i] = 1;
            d_m[i] = 0;
        end
    endfunction

    function automatic void model_push(input logic [15:0] v);
        for (int i = TAPS - 1; i > 0; i--) d_m[i] = d_m[i-1];
        d_m[0] = $signed(v);
    endfunction

    function automatic longint y_val();
        return $signed(y);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        coef_we = 1'b0;
        out_ready = 1'b1;
        #20;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [15:0] v);
        @(negedge clk);
        coef_we = 1'b1;
        coef_addr = a;
        coef_data = v;
        @(negedge clk);
        coef_we = 1'b0;
        h_m[a] = $signed(v);
    endtask

    // Offers one sample (optionally with a same-edge coefficient write), optionally drives
    // ignored in_valid/coef_we noise during MAC, and returns at the first cycle out_valid is seen.
    task automatic do_sample(input logic [15:0] xv, input bit rdy, input bit cw,
                             input logic [3:0] ca, input logic [15:0] cd, input bit noise,
                             output longint yv, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL in_ready_timeout got=0 exp=1");
        end
        in_valid = 1'b1;
        x = xv;
        out_ready = rdy;
        coef_we = cw;
        coef_addr = ca;
        coef_data = cd;
        @(negedge clk);
        if (cw) h_m[ca] = $signed(cd);
        model_push(xv);
        in_valid = noise;
        x = 16'($urandom);
        coef_we = noise;
        coef_addr = 4'd0;
        coef_data = 16'h0007;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        coef_we = 1'b0;
        if (!out_valid) begin
            failures++;
            $display("FAIL out_valid_timeout got=0 exp=1");
        end
        yv = y_val();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        checks++;
        if (y !== 36'd0) begin
            failures++;
            $display("FAIL reset_y got=%0d exp=0", y);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
    endtask

    task automatic test_default_sweep();
        longint yg;
        longint ex;
        int lat;
        apply_reset();
        for (int n = 1; n <= 20; n++) begin
            do_sample(16'd1, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0, yg, lat);
            ex = (n < 16) ? n : 16;
            checks++;
            if (yg !== ex) begin
                failures++;
                $display("FAIL default_sweep n=%0d got=%0d exp=%0d", n, yg, ex);
            end
        end
    endtask

    task automatic test_impulse();
        longint yg;
        longint ex;
        int lat;
        apply_reset();
        for (int i = 0; i < TAPS; i++) write_coef(4'(i), 16'(i + 1));
        for (int n = 0; n < 17; n++) begin
            do_sample((n == 0) ? 16'd1 : 16'd0, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0, yg, lat);
            ex = (n < 16) ? n + 1 : 0;
            checks++;
            if (yg !== ex) begin
                failures++;
                $display("FAIL impulse n=%0d got=%0d exp=%0d", n, yg, ex);
            end
        end
    endtask

    task automatic test_backpressure();
        longint yg;
        longint y2;
        int lat;
        do_sample(16'd300, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0, yg, lat);
        checks++;
        if (yg !== model_y()) begin
            failures++;
            $display("FAIL bp_result got=%0d exp=%0d", yg, model_y());
        end
        in_valid = 1'b1;
        x = 16'd999;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y_val() !== yg) begin
                failures++;
                $display("FAIL bp_hold k=%0d got=%0b/%0b/%0d exp=1/0/%0d",
                         k, out_valid, in_ready, y_val(), yg);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got=%0b/%0b exp=0/1", out_valid, in_ready);
        end
        checks++;
        if (y_val() !== yg) begin
            failures++;
            $display("FAIL bp_y_held got=%0d exp=%0d", y_val(), yg);
        end
        do_sample(16'd7, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0, y2, lat);
        checks++;
        if (y2 !== model_y()) begin
            failures++;
            $display("FAIL bp_next got=%0d exp=%0d", y2, model_y());
        end
    endtask

    task automatic test_extremes();
        longint yg;
        int lat;
        for (int i = 0; i < TAPS; i++) write_coef(4'(i), 16'h8000);
        for (int n = 0; n < 16; n++) begin
            do_sample(16'h8000, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0, yg, lat);
            checks++;
            if (yg !== model_y()) begin
                failures++;
                $display("FAIL extremes n=%0d got=%0d exp=%0d", n, yg, model_y());
            end
        end
        checks++;
        if (yg !== 64'sd17179869184) begin
            failures++;
            $display("FAIL extremes_final got=%0d exp=17179869184", yg);
        end
    endtask

    task automatic test_coef_protect();
        longint yg;
        int lat;
        apply_reset();
        write_coef(4'd0, 16'd100);
        do_sample(16'd3, 1'b1, 1'b0, 4'd0, 16'd0, 1'b1, yg, lat);
        checks++;
        if (yg !== 64'sd300) begin
            failures++;
            $display("FAIL coef_protect got=%0d exp=300", yg);
        end
        do_sample(16'd2, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0, yg, lat);
        checks++;
        if (yg !== 64'sd203) begin
            failures++;
            $display("FAIL coef_protect_next got=%0d exp=203", yg);
        end
    endtask

    task automatic test_coef_same_edge();
        longint yg;
        int lat;
        do_sample(16'd9, 1'b1, 1'b1, 4'd0, 16'hfffd, 1'b0, yg, lat);
        checks++;
        if (yg !== model_y()) begin
            failures++;
            $display("FAIL coef_same_edge got=%0d exp=%0d", yg, model_y());
        end
    endtask

    task automatic test_reset_mid();
        longint yg;
        int lat;
        bit bad;
        @(negedge clk);
        in_valid = 1'b1;
        x = 16'd77;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #5;
        checks++;
        if (out_valid !== 1'b0 || y !== 36'd0) begin
            failures++;
            $display("FAIL reset_mid_during got=%0b/%0d exp=0/0", out_valid, y);
        end
        #5;
        reset = 1'b1;
        bad = 1'b0;
        repeat (TAPS + 4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid_no_pulse got=1 exp=0");
        end
        do_sample(16'd5, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0, yg, lat);
        checks++;
        if (yg !== 64'sd5) begin
            failures++;
            $display("FAIL reset_mid_next got=%0d exp=5", yg);
        end
    endtask

    task automatic test_random();
        longint yg;
        int lat;
        bit rdy;
        for (int i = 0; i < TAPS; i++) write_coef(4'(i), 16'($urandom));
        for (int s = 0; s < 24; s++) begin
            rdy = 1'($urandom_range(0, 1));
            do_sample(16'($urandom), rdy, ($urandom_range(0, 3) == 0), 4'($urandom),
                      16'($urandom), 1'($urandom_range(0, 1)), yg, lat);
            checks++;
            if (yg !== model_y()) begin
                failures++;
                $display("FAIL random_y s=%0d got=%0d exp=%0d", s, yg, model_y());
            end
            checks++;
            if (lat !== TAPS) begin
                failures++;
                $display("FAIL random_latency s=%0d got=%0d exp=%0d", s, lat, TAPS);
            end
            if (!rdy) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || y_val() !== yg) begin
                    failures++;
                    $display("FAIL random_hold s=%0d got=%0b/%0d exp=1/%0d",
                             s, out_valid, y_val(), yg);
                end
                out_ready = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_sweep();
        test_impulse();
        test_backpressure();
        test_extremes();
        test_coef_protect();
        test_coef_same_edge();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
